// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer for the byte-lane data memory (DMEM_ARB_FIXED_PRIO_EN: fixed priority, port 0 wins)
module dmem_arbiter #(
    parameter int DEPTH_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        byte0,
    input  logic        byte1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_WORD = 2'b01;
    localparam logic [1:0] CODE_BYTE = 2'b10;

    state_t      state;
    state_t      state_d;
    logic        grant;
    logic        win;

    // Latched access attributes; mem_addr/mem_wdata double as the address/data latch
    logic        lat_port;
    logic        lat_we;
    logic        lat_byte;
    logic        lat_oor;

    logic        sel_we;
    logic        sel_byte;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic [31:0] rd_capture;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 wins any contest; port 1 only when it asks alone
    assign win = ~req0;
`else
    logic        last_grant;

    // Contested grant goes to the port that did not win last time
    assign win = (req0 & req1) ? ~last_grant : req1;

    // Last-grant pointer; reset to 1 so port 0 takes the first contest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= win;
        end
    end
`endif

    assign sel_we     = win ? we1    : we0;
    assign sel_byte   = win ? byte1  : byte0;
    assign sel_addr   = win ? addr1  : addr0;
    assign sel_wdata  = win ? wdata1 : wdata0;
    assign sel_oor    = (sel_addr >> DEPTH_BITS) != 32'd0;
    assign rd_capture = lat_byte ? {24'd0, mem_rdata[7:0]} : mem_rdata;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle each
    always_comb begin
        state_d = state;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the winner, drive the memory codes for the ACCESS cycle, capture and acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_oor   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_write <= CODE_NONE;
            mem_read  <= CODE_NONE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
        end else begin
            // Codes and acks are single-cycle pulses unless re-asserted below
            mem_write <= CODE_NONE;
            mem_read  <= CODE_NONE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;

            if (grant) begin
                lat_port  <= win;
                lat_we    <= sel_we;
                lat_byte  <= sel_byte;
                lat_oor   <= sel_oor;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                // An out-of-range access keeps both codes idle so memory is never touched
                if (!sel_oor) begin
                    if (sel_we) begin
                        mem_write <= sel_byte ? CODE_BYTE : CODE_WORD;
                    end else begin
                        mem_read  <= sel_byte ? CODE_BYTE : CODE_WORD;
                    end
                end
            end

            if (state == ACCESS) begin
                if (lat_port) begin
                    ack1 <= 1'b1;
                    err1 <= lat_oor;
                end else begin
                    ack0 <= 1'b1;
                    err0 <= lat_oor;
                end
                if (!lat_we && !lat_oor) begin
                    if (lat_port) begin
                        rdata1 <= rd_capture;
                    end else begin
                        rdata0 <= rd_capture;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a byte-lane memory and a transaction-level reference
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic        byte0 = 1'b0, byte1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_write, mem_read;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .byte0(byte0), .byte1(byte1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // Environment memory: 256 words, writes on the falling edge, combinational read
    logic [31:0] env_mem [256];
    logic        env_clear = 1'b1;

    always @(negedge clk) begin
        if (env_clear) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 32'd0;
        end else if (mem_write == 2'b01) begin
            env_mem[mem_addr[7:0]] <= mem_wdata;
        end else if (mem_write == 2'b10) begin
            env_mem[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
        end
    end
    assign mem_rdata = env_mem[mem_addr[7:0]];

    typedef struct packed {
        logic        we;
        logic        by;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          port;
        txn_t        t;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rdata [2];
    int          ref_last = 1;
    logic        obs_err [2];
    logic [31:0] obs_rdata [2];
    vec_t        vec [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic by, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.by = by; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic int contest_winner();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - ref_last;
`endif
    endfunction

    // Expected {mem_write, mem_read} during the access cycle
    function automatic logic [3:0] exp_codes(input txn_t t);
        logic [1:0] kind;
        kind = t.by ? 2'b10 : 2'b01;
        if (t.addr >= 32'd256) return 4'b0000;
        return t.we ? {kind, 2'b00} : {2'b00, kind};
    endfunction

    // Reference: a word store array plus the last read result per port
    task automatic model_apply(input int p, input txn_t t, output logic oor);
        int a;
        oor = (t.addr >= 32'd256);
        if (!oor) begin
            a = int'(t.addr);
            if (t.we && t.by)  ref_mem[a] = (ref_mem[a] & 32'hFFFF_FF00) | (t.wdata & 32'hFF);
            else if (t.we)     ref_mem[a] = t.wdata;
            else if (t.by)     ref_rdata[p] = ref_mem[a] & 32'hFF;
            else               ref_rdata[p] = ref_mem[a];
        end
    endtask

    task automatic on_ack(input int p, input txn_t t, input int cyc, input int exp_cyc, input logic [3:0] codes);
        logic oor;
        check("ack_latency", cyc, exp_cyc);
        check("mem_codes", {28'd0, codes}, {28'd0, exp_codes(t)});
        check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
        model_apply(p, t, oor);
        obs_err[p]   = p ? err1 : err0;
        obs_rdata[p] = p ? rdata1 : rdata0;
        check("err", {31'd0, obs_err[p]}, {31'd0, oor});
        check("rdata", obs_rdata[p], ref_rdata[p]);
    endtask

    task automatic drive(input txn_t t0, input txn_t t1);
        we0 = t0.we; byte0 = t0.by; addr0 = t0.addr; wdata0 = t0.wdata;
        we1 = t1.we; byte1 = t1.by; addr1 = t1.addr; wdata1 = t1.wdata;
    endtask

    // One request per enabled port, each dropped at its ack
    task automatic run(input logic e0, input logic e1, input txn_t t0, input txn_t t1);
        int cyc, k, p, exp_p;
        logic d0, d1;
        logic [3:0] prev;
        cyc = 0; k = 0; d0 = !e0; d1 = !e1; prev = 4'd0;
        exp_p = (e0 && e1) ? contest_winner() : (e0 ? 0 : 1);
        drive(t0, t1);
        req0 = e0; req1 = e1;
        while (!(d0 && d1) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                check("grant_port", p, exp_p);
                on_ack(p, p ? t1 : t0, cyc, 2 + 3 * k, prev);
                if (p == 0) begin req0 = 1'b0; d0 = 1'b1; end
                else        begin req1 = 1'b0; d1 = 1'b1; end
                ref_last = p; k++; exp_p = 1 - p;
            end
            prev = {mem_write, mem_read};
        end
        if (!(d0 && d1)) begin
            total++; bad++;
            $display("FAIL ack_timeout actual=%0d acks required=%0d", k, int'(e0) + int'(e1));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        check("ack_idle", {30'd0, ack0, ack1}, 32'd0);
    endtask

    // Both ports held high for n accesses; returns the grant order, bit k = port of access k
    task automatic run_held(input txn_t t0, input txn_t t1, input int n, output logic [3:0] order);
        int cyc, k, p;
        logic [3:0] prev;
        cyc = 0; k = 0; prev = 4'd0; order = 4'd0;
        drive(t0, t1);
        req0 = 1'b1; req1 = 1'b1;
        while (k < n && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                check("held_grant", p, contest_winner());
                on_ack(p, p ? t1 : t0, cyc, 2 + 3 * k, prev);
                order[k] = p[0];
                ref_last = p; k++;
            end
            prev = {mem_write, mem_read};
        end
        if (k < n) begin
            total++; bad++;
            $display("FAIL held_timeout actual=%0d acks required=%0d", k, n);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {24'd0, ack0, ack1, err0, err1, mem_write, mem_read}, 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic set_vec(input int i, input int port, input logic we, input logic by,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic e, input logic [31:0] r);
        vec[i].port = port; vec[i].t = mk(we, by, a, d);
        vec[i].exp_err = e; vec[i].exp_rdata = r;
    endtask

    function automatic txn_t rand_txn();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = 32'h100 << $urandom_range(0, 23);
        else                           a = $urandom_range(0, 15);
        return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    endfunction

    initial begin
        txn_t idle_t, ta, tb2;
        logic [3:0] order;
        logic seen;
        int m;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
        idle_t = mk(1'b0, 1'b0, 32'd0, 32'd0);

        set_vec(0,  0, 1, 0, 32'h05, 32'hDEADBEEF, 0, 32'h0);
        set_vec(1,  0, 0, 0, 32'h05, 32'h0,        0, 32'hDEADBEEF);
        set_vec(2,  1, 1, 0, 32'h10, 32'h11223344, 0, 32'h0);
        set_vec(3,  1, 1, 1, 32'h10, 32'hAAAAAA7A, 0, 32'h0);
        set_vec(4,  1, 0, 1, 32'h10, 32'h0,        0, 32'h0000007A);
        set_vec(5,  1, 0, 0, 32'h10, 32'h0,        0, 32'h1122337A);
        set_vec(6,  0, 0, 0, 32'h00, 32'h0,        0, 32'h0);
        set_vec(7,  0, 1, 0, 32'h100, 32'hFFFFFFFF, 1, 32'h0);
        set_vec(8,  0, 0, 0, 32'h00, 32'h0,        0, 32'h0);
        set_vec(9,  0, 0, 1, 32'h05, 32'h0,        0, 32'h000000EF);
        set_vec(10, 0, 1, 0, 32'hFF, 32'h12345678, 0, 32'h000000EF);
        set_vec(11, 1, 0, 0, 32'hFF, 32'h0,        0, 32'h12345678);
        set_vec(12, 1, 0, 1, 32'h80000000, 32'h0,  1, 32'h12345678);

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        env_clear = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, one port at a time
        for (int i = 0; i < 13; i++) begin
            if (vec[i].port == 0) run(1'b1, 1'b0, vec[i].t, idle_t);
            else                  run(1'b0, 1'b1, idle_t, vec[i].t);
            check($sformatf("vec%0d_err", i), {31'd0, obs_err[vec[i].port]}, {31'd0, vec[i].exp_err});
            check($sformatf("vec%0d_rdata", i), obs_rdata[vec[i].port], vec[i].exp_rdata);
        end

        // Both ports held for four accesses; last grant was port 1
        run_held(mk(1'b0, 1'b0, 32'h05, 32'h0), mk(1'b0, 1'b0, 32'h10, 32'h0), 4, order);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check("held_order", {28'd0, order}, 32'b0000);
`else
        check("held_order", {28'd0, order}, 32'b1010);
`endif

        // Reset in the first half of a write ACCESS cycle
        drive(mk(1'b1, 1'b0, 32'h20, 32'hCAFEF00D), idle_t);
        req0 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_mem_write", {30'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_last = 1;
        ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack0 || ack1) seen = 1'b1;
        end
        check("no_ack_after_rst", {31'd0, seen}, 32'd0);
        run(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h20, 32'h0), idle_t);
        check("lost_write", obs_rdata[0], 32'h0);
        run(1'b1, 1'b1, mk(1'b0, 1'b0, 32'h05, 32'h0), mk(1'b0, 1'b0, 32'h10, 32'h0));

        // Randomized traffic against the reference
        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(0, 2);
            ta = rand_txn();
            tb2 = rand_txn();
            run(m != 1, m != 0, ta, tb2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-lane data memory (256 entries × 4 byte banks, writes on the falling clock edge). It shares the memory between the CPU load/store port (port 0) and a DMA/debug port (port 1). Each access gets one registered ACCESS cycle with MemWrite/MemRead codes driven from flops, and read data is captured into a per-port response register. Out-of-range addresses are rejected without touching memory.

## Interface
- DEPTH_BITS, 8, number of valid word-index bits; any set bit in addr[31:DEPTH_BITS] is out of range
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, port 0 (CPU) / port 1 (DMA)
- we0 / we1  in  1  1 = write, 0 = read
- byte0 / byte1  in  1  1 = byte access (lane 0 only), 0 = word access
- addr0 / addr1  in  32  word-index address
- wdata0 / wdata1  in  32  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack: address out of range
- rdata0 / rdata1  out  32  read response, held until that port's next ack
- mem_addr  out  32  to memory Address
- mem_wdata  out  32  to memory Write_data
- mem_write  out  2  to MemWrite: 00 none, 01 word, 10 byte
- mem_read  out  2  to MemRead: 01 word, 10 byte, 00 idle
- mem_rdata  in  32  from memory Read_data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, latch the winner's we/byte/addr/wdata and port id, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration is round-robin on a last-grant pointer. With both requests high, the port other than the last grant wins. With one request high, that port wins. The pointer updates on every grant and resets to 1, so port 0 wins the first contest.
- ACCESS: mem_* are driven from the latched registers for exactly this cycle.
  - Word write: mem_write=01. Byte write: mem_write=10.
  - Read: mem_write=00, mem_read=01 for word, 10 for byte.
  - At the rising edge that ends ACCESS, capture mem_rdata into the granted port's rdata on a read. A byte read yields {24'd0, byte}.
  - Then go to RESP.
- Out of range (addr[31:DEPTH_BITS]≠0): ACCESS still occupies one cycle, but mem_write=00 and mem_read=00. rdata is left unchanged and err is set in RESP.
- RESP: the granted port's ack=1 (and err if flagged) for one cycle, then go to IDLE.
- Requester handshake: hold req and all fields stable until ack. A req still high in the cycle after ack counts as a new request.
- Outside ACCESS, mem_write=00, mem_read=00, and mem_addr/mem_wdata keep their last values.
- A req arriving or dropping while ACCESS or RESP is in progress has no effect on the current access.

## Timing
- req sampled high at edge N → ACCESS during cycle N+1 → memory write on the falling edge inside N+1 → ack high during N+2.
- Latency is 2 cycles from sampling to ack. Peak throughput is one access per 3 cycles.
- Reset values: state IDLE, pointer=1, ack0/1=0, err0/1=0, rdata0/1=0, mem_addr=0, mem_wdata=0, mem_write=00, mem_read=00.
- Reset mid-ACCESS: mem_write clears asynchronously. The write is lost if reset asserts before the falling edge. No ack is issued and the requester must re-request.
- All outputs are registered; no combinational path from req to mem_* or ack.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both requests are high, and the pointer is unused.
- Not defined: round-robin as described above.

## Test plan
- Word write then read, port 0: write addr 0x05 data 0xDEADBEEF, then read 0x05 → ack0 two cycles after each req, rdata0=0xDEADBEEF, mem_write=01 only during the write ACCESS cycle.
- Byte read, port 1: byte write 0x7A to addr 0x10 after a word write of 0x11223344 to 0x10, then byte read 0x10 → rdata1=0x0000007A.
- Simultaneous requests, both held high for 4 accesses → grants alternate 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN → 0,0,0,0.
- Out of range: addr0=0x100 write 0xFFFFFFFF → ack0=1, err0=1, mem_write stays 00, and a following read of 0x00 returns its prior value.
- rst_n asserted low in the first half of a write ACCESS → no memory change, all outputs 0, no ack. After release, the next contest is won by port 0.
